// File: rtl/demux1_to_4_tdm.sv
// demux1_to_4_tdm
// Receive side of a 4-channel time-division link. Each enabled cycle carries
// one slot (0,1,2,3); slot 0 is flagged by frame. Slots 0..2 are held in
// shadow registers and all four channel outputs are loaded together when
// slot 3 arrives, so a consumer never sees channels from different frames.
// A framing violation drops the partial frame and reports a one-cycle
// sync_err pulse.

module demux1_to_4_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    input  logic             frame,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       slot;
    logic [WIDTH-1:0] sh0;
    logic [WIDTH-1:0] sh1;
    logic [WIDTH-1:0] sh2;

    // Framing FSM, slot counter, shadow capture and atomic output update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= HUNT;
            slot       <= 2'd0;
            // NOTE: the shadow registers are cleared too, so a frame that
            // straddles a reset can never leak stale channel data.
            sh0        <= '0;
            sh1        <= '0;
            sh2        <= '0;
            out0       <= '0;
            out1       <= '0;
            out2       <= '0;
            out3       <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments everywhere here, so every read
            // below sees the value from before this edge regardless of order.
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (en) begin
                unique case (state)
                    HUNT: begin
                        // Wait for a slot-0 marker; anything else is discarded.
                        if (frame) begin
                            sh0   <= din;
                            slot  <= 2'd1;
                            state <= LOCK;
                        end
                    end
                    LOCK: begin
                        if (slot == 2'd0) begin
                            if (frame) begin
                                sh0  <= din;
                                slot <= 2'd1;
                            end else begin
                                // Expected marker is missing: lose lock.
                                sync_err <= 1'b1;
                                state    <= HUNT;
                            end
                        end else if (frame) begin
                            // Marker arrived early: drop the partial frame and
                            // treat this sample as slot 0 of a new frame.
                            sync_err <= 1'b1;
                            sh0      <= din;
                            slot     <= 2'd1;
                        end else begin
                            unique case (slot)
                                2'd1: begin
                                    sh1  <= din;
                                    slot <= 2'd2;
                                end
                                2'd2: begin
                                    sh2  <= din;
                                    slot <= 2'd3;
                                end
                                default: begin
                                    // Slot 3 completes the frame.
                                    out0       <= sh0;
                                    out1       <= sh1;
                                    out2       <= sh2;
                                    out3       <= din;
                                    frame_done <= 1'b1;
                                    slot       <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign s1     = slot[1];
    assign s0     = slot[0];
    assign locked = (state == LOCK);

endmodule

// File: tb/tb_demux1_to_4_tdm.sv
// tb_demux1_to_4_tdm
// Directed, table-driven bench for demux1_to_4_tdm (WIDTH=1). Each table row
// gives the inputs for one clock edge and the outputs expected after it.

module tb_demux1_to_4_tdm;

    logic clk = 1'b0;
    logic reset;
    logic en;
    logic din;
    logic frame;
    logic out0, out1, out2, out3;
    logic s1, s0, locked, frame_done, sync_err;

    int checks = 0;
    int errors = 0;

    demux1_to_4_tdm #(.WIDTH(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .din        (din),
        .frame      (frame),
        .out0       (out0),
        .out1       (out1),
        .out2       (out2),
        .out3       (out3),
        .s1         (s1),
        .s0         (s0),
        .locked     (locked),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic       frm;
        logic       din;
        logic [3:0] outs;   // {out0,out1,out2,out3}
        logic [1:0] slot;
        logic       lk;
        logic       fd;
        logic       se;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic e, input logic f, input logic d,
                       input logic [3:0] o, input logic [1:0] s,
                       input logic lk, input logic fd, input logic se);
        vec_t v;
        v.rst = r; v.en = e; v.frm = f; v.din = d;
        v.outs = o; v.slot = s; v.lk = lk; v.fd = fd; v.se = se;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic d);
        @(negedge clk);
        reset = r; en = e; frame = f; din = d;
        @(posedge clk);
        #1;
    endtask

    int fd_count;
    int se_count;

    initial begin
        reset = 1'b1; en = 1'b0; frame = 1'b0; din = 1'b0;

        //   rst en frm din  outs     slot lk fd se
        // Reset held two cycles with arbitrary inputs
        add(1, 1, 1, 1, 4'b0000, 2'd0, 0, 0, 0);
        add(1, 0, 0, 1, 4'b0000, 2'd0, 0, 0, 0);
        // Nominal frame 1,0,1,0
        add(0, 1, 1, 1, 4'b0000, 2'd1, 1, 0, 0);
        add(0, 1, 0, 0, 4'b0000, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0000, 2'd3, 1, 0, 0);
        add(0, 1, 0, 0, 4'b1010, 2'd0, 1, 1, 0);
        add(0, 0, 0, 1, 4'b1010, 2'd0, 1, 0, 0);
        // Same frame with three stall cycles between slots 1 and 2
        add(0, 1, 1, 1, 4'b1010, 2'd1, 1, 0, 0);
        add(0, 1, 0, 0, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 0, 1, 1, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 0, 0, 0, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 0, 1, 1, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b1010, 2'd3, 1, 0, 0);
        add(0, 1, 0, 0, 4'b1010, 2'd0, 1, 1, 0);
        // Early sync at slot 2, then realigned frame 0,1,1,0
        add(0, 1, 1, 1, 4'b1010, 2'd1, 1, 0, 0);
        add(0, 1, 0, 1, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 1, 1, 0, 4'b1010, 2'd1, 1, 0, 1);
        add(0, 1, 0, 1, 4'b1010, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b1010, 2'd3, 1, 0, 0);
        add(0, 1, 0, 0, 4'b0110, 2'd0, 1, 1, 0);
        // Missing sync at slot 0, HUNT discards, relock with frame 0,0,1,1
        add(0, 1, 0, 1, 4'b0110, 2'd0, 0, 0, 1);
        add(0, 1, 0, 1, 4'b0110, 2'd0, 0, 0, 0);
        add(0, 1, 1, 0, 4'b0110, 2'd1, 1, 0, 0);
        add(0, 1, 0, 0, 4'b0110, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0110, 2'd3, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0011, 2'd0, 1, 1, 0);
        // Reset after slot 2, overriding the would-be slot-3 completion
        add(0, 1, 1, 1, 4'b0011, 2'd1, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0011, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0011, 2'd3, 1, 0, 0);
        add(1, 1, 0, 1, 4'b0000, 2'd0, 0, 0, 0);
        add(0, 1, 0, 1, 4'b0000, 2'd0, 0, 0, 0);
        add(0, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(0, 1, 1, 0, 4'b0000, 2'd1, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0000, 2'd2, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0000, 2'd3, 1, 0, 0);
        add(0, 1, 0, 1, 4'b0111, 2'd0, 1, 1, 0);
        // Early sync at slot 3 drops the frame instead of completing it
        add(0, 1, 1, 1, 4'b0111, 2'd1, 1, 0, 0);
        add(0, 1, 0, 0, 4'b0111, 2'd2, 1, 0, 0);
        add(0, 1, 0, 0, 4'b0111, 2'd3, 1, 0, 0);
        add(0, 1, 1, 0, 4'b0111, 2'd1, 1, 0, 1);
        add(0, 0, 0, 0, 4'b0111, 2'd1, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].frm, vecs[i].din);
            check($sformatf("row%0d outs", i), {out0, out1, out2, out3}, vecs[i].outs);
            check($sformatf("row%0d slot", i), {2'b00, s1, s0}, {2'b00, vecs[i].slot});
            check($sformatf("row%0d locked", i), {3'b000, locked}, {3'b000, vecs[i].lk});
            check($sformatf("row%0d frame_done", i), {3'b000, frame_done}, {3'b000, vecs[i].fd});
            check($sformatf("row%0d sync_err", i), {3'b000, sync_err}, {3'b000, vecs[i].se});
        end

        // Hand sequence: reset, then an all-ones frame with a stall after
        // every slot. Exactly one frame_done and no sync_err are expected.
        drive(1, 0, 0, 0);
        fd_count = 0;
        se_count = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, (c % 2 == 0) && (c < 8), (c == 0), 1'b1);
            if (frame_done) fd_count++;
            if (sync_err) se_count++;
        end
        check("stall frame_done count", fd_count[3:0], 4'd1);
        check("stall sync_err count", se_count[3:0], 4'd0);
        check("stall outs", {out0, out1, out2, out3}, 4'b1111);

        // Hand sequence: a partial frame followed by reset; no frame_done
        // may appear while idling in HUNT afterwards.
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 0, 0);
        drive(1, 1, 0, 0);
        fd_count = 0;
        for (int c = 0; c < 6; c++) begin
            drive(0, 1, 0, 1'b1);
            if (frame_done) fd_count++;
        end
        check("post-reset frame_done count", fd_count[3:0], 4'd0);
        check("post-reset outs", {out0, out1, out2, out3}, 4'b0000);
        check("post-reset locked", {3'b000, locked}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
